// File: rtl/reorder_buffer_if.sv
// Dispatch / CDB / commit / lookup bundle between the core and the reorder buffer.
interface reorder_buffer_if #(
    parameter int unsigned TAG_W  = 3,
    parameter int unsigned DATA_W = 32
);
    logic              flush;
    logic              alloc_req;
    logic [4:0]        alloc_rd;
    logic              alloc_ready;
    logic [TAG_W-1:0]  alloc_tag;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic              commit_load;
    logic [4:0]        commit_dest;
    logic [DATA_W-1:0] commit_data;
    logic [TAG_W-1:0]  commit_tag;
    logic [TAG_W-1:0]  lk_tag_a;
    logic [TAG_W-1:0]  lk_tag_b;
    logic [DATA_W-1:0] lk_data_a;
    logic [DATA_W-1:0] lk_data_b;
    logic              lk_ready_a;
    logic              lk_ready_b;
    logic [TAG_W:0]    count;
    logic              empty;
    logic              full;

    modport master (
        output flush, alloc_req, alloc_rd, cdb_valid, cdb_tag, cdb_data, lk_tag_a, lk_tag_b,
        input  alloc_ready, alloc_tag, commit_load, commit_dest, commit_data, commit_tag,
               lk_data_a, lk_data_b, lk_ready_a, lk_ready_b, count, empty, full
    );

    modport slave (
        input  flush, alloc_req, alloc_rd, cdb_valid, cdb_tag, cdb_data, lk_tag_a, lk_tag_b,
        output alloc_ready, alloc_tag, commit_load, commit_dest, commit_data, commit_tag,
               lk_data_a, lk_data_b, lk_ready_a, lk_ready_b, count, empty, full
    );
endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: hands out tags, captures CDB results,
// retires in program order and serves operand lookups for in-flight tags.
module reorder_buffer #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned TAG_W  = 3,
    parameter int unsigned DATA_W = 32
) (
    input logic            clk,
    input logic            rst,
    reorder_buffer_if.slave bus
);
    localparam int unsigned RD_W  = 5;
    localparam int unsigned CNT_W = TAG_W + 1;

    typedef enum logic [1:0] {
        E_FREE   = 2'd0,
        E_ISSUED = 2'd1,
        E_DONE   = 2'd2
    } entry_state_e;

    entry_state_e      state_q [DEPTH];
    logic [RD_W-1:0]   rd_q    [DEPTH];
    logic [DATA_W-1:0] data_q  [DEPTH];
    logic [TAG_W-1:0]  head_q;
    logic [TAG_W-1:0]  tail_q;
    logic [CNT_W-1:0]  count_q;

    logic full_c;
    logic alloc_ok_c;
    logic commit_ok_c;
    logic cdb_hit_c;

    // Status and handshake decode from registered state; full uses the pre-edge count.
    assign full_c      = (count_q == CNT_W'(DEPTH));
    assign alloc_ok_c  = bus.alloc_req && !full_c;
    assign commit_ok_c = !bus.flush && (state_q[head_q] == E_DONE);
    assign cdb_hit_c   = bus.cdb_valid && (state_q[bus.cdb_tag] == E_ISSUED);

    assign bus.alloc_ready = !full_c;
    assign bus.alloc_tag   = tail_q;
    assign bus.commit_load = commit_ok_c;
    assign bus.commit_dest = rd_q[head_q];
    assign bus.commit_data = data_q[head_q];
    assign bus.commit_tag  = head_q;
    assign bus.count       = count_q;
    assign bus.empty       = (count_q == '0);
    assign bus.full        = full_c;

    // Operand lookup: same-cycle CDB bypass for an issued entry, else stored result when done.
    function automatic logic [DATA_W:0] lookup(input logic [TAG_W-1:0] tag);
        logic [DATA_W:0] res;
        res = '0;
        if (bus.cdb_valid && (bus.cdb_tag == tag) && (state_q[tag] == E_ISSUED)) begin
            res = {1'b1, bus.cdb_data};
        end else if (state_q[tag] == E_DONE) begin
            res = {1'b1, data_q[tag]};
        end
        return res;
    endfunction

    // Lookup port A.
    always_comb begin
        {bus.lk_ready_a, bus.lk_data_a} = lookup(bus.lk_tag_a);
    end

    // Lookup port B.
    always_comb begin
        {bus.lk_ready_b, bus.lk_data_b} = lookup(bus.lk_tag_b);
    end

    // Entry state, pointers and occupancy; flush squashes everything in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                state_q[i] <= E_FREE;
                rd_q[i]    <= '0;
                data_q[i]  <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (bus.flush) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                state_q[i] <= E_FREE;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            // The CDB only targets issued entries, which are never the head being retired
            // nor the free tail slot being allocated, so these updates never collide.
            if (cdb_hit_c) begin
                state_q[bus.cdb_tag] <= E_DONE;
                data_q[bus.cdb_tag]  <= bus.cdb_data;
            end
            if (commit_ok_c) begin
                state_q[head_q] <= E_FREE;
                head_q          <= head_q + TAG_W'(1);
            end
            if (alloc_ok_c) begin
                state_q[tail_q] <= E_ISSUED;
                rd_q[tail_q]    <= bus.alloc_rd;
                tail_q          <= tail_q + TAG_W'(1);
            end
            count_q <= count_q + CNT_W'(alloc_ok_c) - CNT_W'(commit_ok_c);
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed plus randomized bench for reorder_buffer against a program-order queue model.
module tb_reorder_buffer;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned TAG_W  = 3;
    localparam int unsigned DATA_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    reorder_buffer_if #(.TAG_W(TAG_W), .DATA_W(DATA_W)) bus ();

    reorder_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Model: in-flight instructions in program order; head tag tracked separately.
    typedef struct {
        logic [4:0]        rd;
        logic              done;
        logic [DATA_W-1:0] data;
    } ent_t;

    ent_t q[$];
    int   m_head = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pos_of(input int t);
        return (t - m_head + int'(DEPTH)) % int'(DEPTH);
    endfunction

    function automatic logic [DATA_W:0] m_lookup(input int t);
        int i;
        i = pos_of(t);
        if (i < q.size()) begin
            if (!q[i].done && bus.cdb_valid && (int'(bus.cdb_tag) == t)) return {1'b1, bus.cdb_data};
            if (q[i].done) return {1'b1, q[i].data};
        end
        return '0;
    endfunction

    task automatic check_outputs();
        int              size;
        logic            cl;
        logic [DATA_W:0] la;
        logic [DATA_W:0] lb;
        size = q.size();
        cl   = !bus.flush && (size > 0) && q[0].done;
        la   = m_lookup(int'(bus.lk_tag_a));
        lb   = m_lookup(int'(bus.lk_tag_b));
        chk("alloc_ready", 64'(bus.alloc_ready), 64'(size < int'(DEPTH)));
        chk("alloc_tag", 64'(bus.alloc_tag), 64'((m_head + size) % int'(DEPTH)));
        chk("commit_load", 64'(bus.commit_load), 64'(cl));
        chk("commit_tag", 64'(bus.commit_tag), 64'(m_head));
        if (size > 0) chk("commit_dest", 64'(bus.commit_dest), 64'(q[0].rd));
        if (cl) chk("commit_data", 64'(bus.commit_data), 64'(q[0].data));
        chk("lk_a", 64'({bus.lk_ready_a, bus.lk_data_a}), 64'(la));
        chk("lk_b", 64'({bus.lk_ready_b, bus.lk_data_b}), 64'(lb));
        chk("count", 64'(bus.count), 64'(size));
        chk("empty", 64'(bus.empty), 64'(size == 0));
        chk("full", 64'(bus.full), 64'(size == int'(DEPTH)));
    endtask

    // Advance the model by one clock edge using the inputs held during the cycle.
    task automatic model_edge();
        int   size;
        int   i;
        logic do_commit;
        logic do_alloc;
        ent_t e;
        size      = q.size();
        do_commit = !bus.flush && (size > 0) && q[0].done;
        do_alloc  = bus.alloc_req && (size < int'(DEPTH));
        if (bus.flush) begin
            q.delete();
            m_head = 0;
        end else begin
            if (bus.cdb_valid) begin
                i = pos_of(int'(bus.cdb_tag));
                if (i < size && !q[i].done) begin
                    q[i].done = 1'b1;
                    q[i].data = bus.cdb_data;
                end
            end
            if (do_commit) begin
                void'(q.pop_front());
                m_head = (m_head + 1) % int'(DEPTH);
            end
            if (do_alloc) begin
                e.rd   = bus.alloc_rd;
                e.done = 1'b0;
                e.data = '0;
                q.push_back(e);
            end
        end
    endtask

    task automatic drive(input logic fl, input logic ar, input logic [4:0] rd,
                         input logic cv, input logic [TAG_W-1:0] ct, input logic [DATA_W-1:0] cd,
                         input logic [TAG_W-1:0] la, input logic [TAG_W-1:0] lb);
        @(negedge clk);
        bus.flush     = fl;
        bus.alloc_req = ar;
        bus.alloc_rd  = rd;
        bus.cdb_valid = cv;
        bus.cdb_tag   = ct;
        bus.cdb_data  = cd;
        bus.lk_tag_a  = la;
        bus.lk_tag_b  = lb;
        #1;
        check_outputs();
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
    endtask

    task automatic cyc(input logic fl, input logic ar, input logic [4:0] rd,
                       input logic cv, input logic [TAG_W-1:0] ct, input logic [DATA_W-1:0] cd,
                       input logic [TAG_W-1:0] la, input logic [TAG_W-1:0] lb);
        drive(fl, ar, rd, cv, ct, cd, la, lb);
        tick();
    endtask

    task automatic reset_checks(input string pfx);
        chk({pfx, "_alloc_ready"}, 64'(bus.alloc_ready), 64'(1));
        chk({pfx, "_alloc_tag"}, 64'(bus.alloc_tag), 64'(0));
        chk({pfx, "_commit_load"}, 64'(bus.commit_load), 64'(0));
        chk({pfx, "_commit_dest"}, 64'(bus.commit_dest), 64'(0));
        chk({pfx, "_commit_data"}, 64'(bus.commit_data), 64'(0));
        chk({pfx, "_commit_tag"}, 64'(bus.commit_tag), 64'(0));
        chk({pfx, "_lk_a"}, 64'({bus.lk_ready_a, bus.lk_data_a}), 64'(0));
        chk({pfx, "_lk_b"}, 64'({bus.lk_ready_b, bus.lk_data_b}), 64'(0));
        chk({pfx, "_count"}, 64'(bus.count), 64'(0));
        chk({pfx, "_empty"}, 64'(bus.empty), 64'(1));
        chk({pfx, "_full"}, 64'(bus.full), 64'(0));
    endtask

    initial begin
        logic       fl;
        logic       ar;
        logic       cv;
        logic [2:0] ct;
        logic [2:0] la;

        bus.flush = 1'b0; bus.alloc_req = 1'b0; bus.alloc_rd = '0;
        bus.cdb_valid = 1'b0; bus.cdb_tag = '0; bus.cdb_data = '0;
        bus.lk_tag_a = '0; bus.lk_tag_b = '0;

        // Reset state.
        #12;
        reset_checks("rst");
        @(negedge clk);
        #2 rst = 1'b1;

        // Eight allocations rd=1..8 fill the ROB; a ninth is ignored.
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 5'(i + 1), 1'b0, '0, '0, '0, '0);
            chk("fill_alloc_tag", 64'(bus.alloc_tag), 64'(i));
            tick();
        end
        drive(1'b0, 1'b1, 5'd9, 1'b0, '0, '0, '0, '0);
        chk("fill_full", 64'(bus.full), 64'(1));
        chk("fill_ready", 64'(bus.alloc_ready), 64'(0));
        tick();
        drive(1'b0, 1'b0, '0, 1'b0, '0, '0, '0, '0);
        chk("fill_count8", 64'(bus.count), 64'(8));
        tick();

        // Out-of-order completion, in-order retirement.
        cyc(1'b0, 1'b0, '0, 1'b1, 3'd2, 32'hAA, 3'd2, 3'd0);
        drive(1'b0, 1'b0, '0, 1'b1, 3'd0, 32'h11, 3'd2, 3'd0);
        chk("ooo_no_commit", 64'(bus.commit_load), 64'(0));
        tick();
        drive(1'b0, 1'b0, '0, 1'b1, 3'd1, 32'h22, 3'd0, 3'd1);
        chk("ooo_c0_load", 64'(bus.commit_load), 64'(1));
        chk("ooo_c0_data", 64'(bus.commit_data), 64'h11);
        chk("ooo_c0_dest", 64'(bus.commit_dest), 64'(1));
        tick();
        drive(1'b0, 1'b0, '0, 1'b0, '0, '0, '0, '0);
        chk("ooo_c1_data", 64'(bus.commit_data), 64'h22);
        chk("ooo_c1_dest", 64'(bus.commit_dest), 64'(2));
        tick();
        drive(1'b0, 1'b0, '0, 1'b0, '0, '0, '0, '0);
        chk("ooo_c2_tag", 64'(bus.commit_tag), 64'(2));
        chk("ooo_c2_data", 64'(bus.commit_data), 64'hAA);
        chk("ooo_c2_dest", 64'(bus.commit_dest), 64'(3));
        tick();

        // Lookup bypass from the CDB, then from storage.
        drive(1'b0, 1'b0, '0, 1'b1, 3'd3, 32'h5, 3'd3, 3'd4);
        chk("byp_ready", 64'(bus.lk_ready_a), 64'(1));
        chk("byp_data", 64'(bus.lk_data_a), 64'h5);
        tick();
        drive(1'b0, 1'b0, '0, 1'b0, '0, '0, 3'd3, 3'd4);
        chk("stor_ready", 64'(bus.lk_ready_a), 64'(1));
        chk("stor_data", 64'(bus.lk_data_a), 64'h5);
        tick();

        // Refill to full, complete the head, then commit and alloc in the same cycle.
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 5'(20 + i), 1'b0, '0, '0, '0, '0);
        cyc(1'b0, 1'b0, '0, 1'b1, 3'd4, 32'h44, 3'd4, 3'd0);
        drive(1'b0, 1'b1, 5'd30, 1'b0, '0, '0, '0, '0);
        chk("wrap_full", 64'(bus.full), 64'(1));
        chk("wrap_commit", 64'(bus.commit_load), 64'(1));
        tick();
        drive(1'b0, 1'b1, 5'd31, 1'b0, '0, '0, '0, '0);
        chk("wrap_count7", 64'(bus.count), 64'(7));
        chk("wrap_tag", 64'(bus.alloc_tag), 64'(4));
        tick();

        // Drain to five entries, then flush with a CDB hit in flight.
        cyc(1'b0, 1'b0, '0, 1'b1, 3'd5, 32'h55, '0, '0);
        cyc(1'b0, 1'b0, '0, 1'b1, 3'd6, 32'h66, '0, '0);
        cyc(1'b0, 1'b0, '0, 1'b1, 3'd7, 32'h77, '0, '0);
        cyc(1'b0, 1'b0, '0, 1'b0, '0, '0, '0, '0);
        drive(1'b1, 1'b1, 5'd7, 1'b1, 3'd1, 32'h99, 3'd1, 3'd2);
        chk("fl_count5", 64'(bus.count), 64'(5));
        tick();
        drive(1'b0, 1'b0, '0, 1'b0, '0, '0, 3'd1, 3'd0);
        chk("fl_count", 64'(bus.count), 64'(0));
        chk("fl_empty", 64'(bus.empty), 64'(1));
        chk("fl_commit", 64'(bus.commit_load), 64'(0));
        chk("fl_lk_ready", 64'(bus.lk_ready_a), 64'(0));
        tick();

        // Asynchronous reset while a commit is pending.
        cyc(1'b0, 1'b1, 5'd9, 1'b0, '0, '0, '0, '0);
        cyc(1'b0, 1'b1, 5'd10, 1'b0, '0, '0, '0, '0);
        cyc(1'b0, 1'b0, '0, 1'b1, 3'd0, 32'h77, '0, '0);
        drive(1'b0, 1'b0, '0, 1'b0, '0, '0, 3'd0, 3'd1);
        chk("ar_pre_commit", 64'(bus.commit_load), 64'(1));
        #2 rst = 1'b0;
        #1;
        reset_checks("ar");
        q.delete();
        m_head = 0;
        @(negedge clk);
        #2 rst = 1'b1;

        // Randomized traffic against the queue model.
        for (int n = 0; n < 500; n++) begin
            fl = ($urandom_range(0, 31) == 0);
            ar = ($urandom_range(0, 7) < 5);
            cv = ($urandom_range(0, 1) == 1);
            ct = 3'($urandom_range(0, 7));
            la = ($urandom_range(0, 1) == 1) ? ct : 3'($urandom_range(0, 7));
            cyc(fl, ar, 5'($urandom_range(0, 31)), cv, ct, $urandom, la, 3'($urandom_range(0, 7)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order reorder buffer for the Tomasulo-style core.
- Sits between dispatch/reservation stations and the tagged register file.
- Hands out rename tags at dispatch (feeds the regfile `allocate`/`tag_in`) and captures results from the common data bus (CDB).
- Retires results in program order by driving the regfile write port (`load`/`dest`/`in`), and serves operand lookups for not-yet-retired tags.

Parameters:
- DEPTH, 8, number of ROB entries; must equal 2^TAG_W.
- TAG_W, 3, tag width; tag equals entry index.
- DATA_W, 32, result width.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- flush  input  1  synchronous squash of all entries.
- alloc_req  input  1  dispatch requests an entry.
- alloc_rd  input  5  destination register of dispatched instruction.
- alloc_ready  output  1  entry available (not full).
- alloc_tag  output  TAG_W  tag granted (current tail index).
- cdb_valid  input  1  result broadcast valid.
- cdb_tag  input  TAG_W  tag of broadcast result.
- cdb_data  input  DATA_W  broadcast result.
- commit_load  output  1  retire head this cycle (to regfile `load`).
- commit_dest  output  5  head destination register (to regfile `dest`).
- commit_data  output  DATA_W  head result (to regfile `in`).
- commit_tag  output  TAG_W  head tag.
- lk_tag_a  input  TAG_W  operand A lookup tag.
- lk_tag_b  input  TAG_W  operand B lookup tag.
- lk_data_a  output  DATA_W  value for lk_tag_a.
- lk_data_b  output  DATA_W  value for lk_tag_b.
- lk_ready_a  output  1  lk_data_a valid.
- lk_ready_b  output  1  lk_data_b valid.
- count  output  TAG_W+1  occupied entries.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.

Behaviour:
- Per-entry state: FREE -> ISSUED (on alloc) -> DONE (on matching CDB) -> FREE (on commit or flush). Each entry also holds rd[4:0] and data[DATA_W-1:0].
- Reset (rst low, asynchronous):
  - All entries FREE, data/rd zero; head = tail = 0; count = 0.
  - Outputs: alloc_ready=1, alloc_tag=0, commit_load=0, commit_dest=0, commit_data=0, commit_tag=0, lk_ready_*=0, lk_data_*=0, empty=1, full=0.
  - Reset asserted mid-operation discards everything immediately.
- Allocate:
  - alloc_ready = !full.
  - alloc_tag = tail, combinational.
  - When alloc_req && alloc_ready on an edge: entry[tail] becomes ISSUED, rd latched, tail increments modulo DEPTH.
  - alloc_req while full is ignored; no state change.
- Writeback:
  - cdb_valid with entry[cdb_tag] ISSUED: data stored and state becomes DONE at the edge.
  - CDB to a FREE or DONE entry is ignored.
- Commit:
  - commit_load = !flush && entry[head] DONE, combinational from registered state.
  - commit_dest, commit_data and commit_tag reflect the head entry.
  - When commit_load is high on an edge: head is freed and head increments modulo DEPTH.
  - Commit is asserted for rd = 0 as well; the regfile discards it.
  - Minimum latency CDB -> commit_load: 1 cycle; no same-cycle bypass to commit.
- Count:
  - +1 on accepted alloc, -1 on commit; simultaneous alloc and commit leaves count unchanged.
  - full is computed from the pre-edge count: no alloc into a slot freed the same cycle.
- Lookup (combinational, per port):
  - If cdb_valid && cdb_tag == lk_tag and the entry is ISSUED: return cdb_data, ready=1 (bypass).
  - Else if the entry is DONE: return stored data, ready=1.
  - Else: ready=0, data=0.
- Flush:
  - Overrides alloc, CDB and commit in the same cycle.
  - All entries FREE; head = tail = count = 0.
- Pointer wrap-around: head and tail wrap naturally at DEPTH; full and empty are derived from count, not pointer equality.

Test Plan:
- Reset then 8 allocs (rd=1..8) -> alloc_tag 0..7, full=1 after 8th, 9th alloc_req ignored with count=8; regfile allocate sequencing unaffected.
- CDB tag 2 (data 0xAA), then tag 0 (0x11), then tag 1 (0x22) -> no commit until tag 0 DONE; then commits tags 0,1,2 on consecutive cycles with commit_data 0x11, 0x22, 0xAA and commit_dest 1,2,3.
- lk_tag_a=3 while cdb_valid, cdb_tag=3, cdb_data=0x5 -> lk_ready_a=1, lk_data_a=0x5 same cycle; next cycle served from storage.
- Full ROB with head DONE, alloc_req and commit same cycle -> commit occurs, alloc rejected, count 7; alloc on next cycle accepted with alloc_tag = old head index (wrap).
- flush while count=5 and cdb_valid for an ISSUED tag -> count=0, empty=1, commit_load=0, subsequent lookup of that tag returns ready=0.
- Assert rst low asynchronously mid-commit (between edges) -> commit_load drops immediately, all outputs at their reset values.
